// File: rtl/closest_hit_collector.sv
// Closest-hit collector: scans one intersection result per i_valid and reports the nearest hit.
// Optional stray-result counter on o_err_cnt is built only when CLOSEST_HIT_ERR_CNT_EN is defined.
module closest_hit_collector #(
    parameter int                 IDX_W = 16,
    parameter logic signed [31:0] MIN_T = 32'sd0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [IDX_W-1:0]        i_num_tri,
    input  logic                    i_valid,
    input  logic signed [31:0]      i_t,
    input  logic                    i_result,
    output logic                    o_busy,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic                    o_hit,
    output logic signed [31:0]      o_t,
    output logic [IDX_W-1:0]        o_idx,
    output logic [7:0]              o_err_cnt
);

    localparam logic signed [31:0] T_MAX = 32'sh7fffffff;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        OUTPUT
    } state_t;

    state_t                 state;
    logic [IDX_W-1:0]       count;
    logic [IDX_W-1:0]       last_idx;
    logic signed [31:0]     best_t;
    logic [IDX_W-1:0]       best_idx;
    logic                   best_hit;

    logic                   take;
    logic signed [31:0]     nxt_t;
    logic [IDX_W-1:0]       nxt_idx;
    logic                   nxt_hit;

    // Strict less-than keeps the earlier index on ties.
    always_comb begin
        take    = i_result && (i_t >= MIN_T) && (i_t < best_t);
        nxt_t   = take ? i_t   : best_t;
        nxt_idx = take ? count : best_idx;
        nxt_hit = take | best_hit;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            count    <= '0;
            last_idx <= '0;
            best_t   <= T_MAX;
            best_idx <= '0;
            best_hit <= 1'b0;
            o_busy   <= 1'b0;
            o_valid  <= 1'b0;
            o_hit    <= 1'b0;
            o_t      <= T_MAX;
            o_idx    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        o_busy <= 1'b1;
                        if (i_num_tri != '0) begin
                            state    <= COLLECT;
                            count    <= '0;
                            last_idx <= i_num_tri - IDX_W'(1);
                            best_t   <= T_MAX;
                            best_idx <= '0;
                            best_hit <= 1'b0;
                        end else begin
                            state   <= OUTPUT;
                            o_valid <= 1'b1;
                            o_hit   <= 1'b0;
                            o_t     <= T_MAX;
                            o_idx   <= '0;
                        end
                    end
                end
                COLLECT: begin
                    if (i_valid) begin
                        count    <= count + IDX_W'(1);
                        best_t   <= nxt_t;
                        best_idx <= nxt_idx;
                        best_hit <= nxt_hit;
                        // Last result is folded in directly so the record appears next cycle.
                        if (count == last_idx) begin
                            state   <= OUTPUT;
                            o_valid <= 1'b1;
                            o_hit   <= nxt_hit;
                            o_t     <= nxt_t;
                            o_idx   <= nxt_idx;
                        end
                    end
                end
                OUTPUT: begin
                    if (i_ready) begin
                        state   <= IDLE;
                        o_busy  <= 1'b0;
                        o_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CLOSEST_HIT_ERR_CNT_EN
    logic drop;
    assign drop = i_valid && (state != COLLECT);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_err_cnt <= '0;
        end else if (drop && (o_err_cnt != 8'hff)) begin
            o_err_cnt <= o_err_cnt + 8'd1;
        end
    end
`else
    assign o_err_cnt = '0;
`endif

endmodule
